// File: rtl/mc_datapath_ctrl.sv
// Multi-cycle datapath controller.
// Sequences fetch, decode, execute and writeback, and drives the register
// loads, register-file addressing, ALU strobe and PC increment for each
// instruction. After a start pulse it keeps running until HALT or an
// illegal opcode.
module mc_datapath_ctrl #(
  parameter int MUL_CYCLES = 4,  // EXEC cycles spent on MUL (2..15)
  parameter int OPW        = 4   // opcode width, tied to IR[7:4]
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           mem_ack,
  input  logic [7:0]     instr,
  output logic           mem_rd,
  output logic           ir_load,
  output logic           op_load,
  output logic [OPW-1:0] opcode,
  output logic           a_load,
  output logic           b_load,
  output logic [1:0]     raddr_a,
  output logic [1:0]     raddr_b,
  output logic [1:0]     waddr,
  output logic           alu_go,
  output logic           rf_we,
  output logic           pc_inc,
  output logic           busy,
  output logic           halted,
  output logic           err,
  output logic [2:0]     state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  localparam logic [OPW-1:0] OP_NOP  = OPW'(4'h0);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(4'h8);
  localparam logic [OPW-1:0] OP_HALT = OPW'(4'hF);
  // The counter is preloaded so that it reaches zero in the last MUL cycle.
  localparam logic [3:0]     MUL_LOAD = 4'(MUL_CYCLES - 1);

  state_t         r_state;
  state_t         w_next;
  logic [7:0]     r_ir;
  logic [3:0]     r_cnt;
  logic [OPW-1:0] w_op;
  logic           w_is_alu;
  logic           w_is_mul;

  assign w_op     = r_ir[7:4];
  assign w_is_mul = (w_op == OP_MUL);
  // Opcodes 1..8 all take operands and go through EXEC; 8 is MUL.
  assign w_is_alu = (w_op >= OPW'(4'h1)) && (w_op <= OP_MUL);

  // State register; reset dominates start and abandons any instruction.
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // the pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Instruction register: captures instr on the acknowledged fetch cycle.
  always_ff @(posedge clock) begin
    if (reset)                             r_ir <= 8'h00;
    else if (r_state == S_FETCH && mem_ack) r_ir <= instr;
  end

  // MUL cycle counter: loaded in DECODE, counts down through EXEC.
  always_ff @(posedge clock) begin
    if (reset)                                  r_cnt <= 4'd0;
    else if (r_state == S_DECODE && w_is_mul)   r_cnt <= MUL_LOAD;
    else if (r_state == S_EXEC && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
  end

  // Next-state decode.
  // NOTE: every always_comb output gets a default on entry, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH:  if (mem_ack) w_next = S_DECODE;
      S_DECODE: begin
        if (w_op == OP_NOP)       w_next = S_FETCH;
        else if (w_is_alu)        w_next = S_EXEC;
        else if (w_op == OP_HALT) w_next = S_HALTED;
        else                      w_next = S_IDLE;   // illegal opcode
      end
      S_EXEC:   if (!w_is_mul || r_cnt == 4'd0) w_next = S_WB;
      S_WB:     w_next = S_FETCH;
      S_HALTED: if (start) w_next = S_FETCH;
      default:  w_next = S_IDLE;                    // codes 6/7 recover
    endcase
  end

  // Output decode from state, IR and the memory handshake.
  always_comb begin
    mem_rd  = 1'b0;
    ir_load = 1'b0;
    op_load = 1'b0;
    a_load  = 1'b0;
    b_load  = 1'b0;
    alu_go  = 1'b0;
    rf_we   = 1'b0;
    pc_inc  = 1'b0;
    err     = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_rd  = 1'b1;
        ir_load = mem_ack;
      end
      S_DECODE: begin
        if (w_is_alu) begin
          op_load = 1'b1;
          a_load  = 1'b1;
          b_load  = 1'b1;
        end else if (w_op == OP_NOP || w_op == OP_HALT) begin
          pc_inc = 1'b1;
        end else begin
          err = 1'b1;
        end
      end
      S_EXEC:  alu_go = 1'b1;
      S_WB: begin
        rf_we  = 1'b1;
        pc_inc = 1'b1;
      end
      default: ;
    endcase
  end

  // Register-file addressing always follows the latched instruction.
  assign opcode    = w_op;
  assign raddr_a   = r_ir[3:2];
  assign raddr_b   = r_ir[1:0];
  assign waddr     = r_ir[3:2];
  assign busy      = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                     (r_state == S_EXEC)  || (r_state == S_WB);
  assign halted    = (r_state == S_HALTED);
  assign state_dbg = r_state;

endmodule

// File: tb/tb_mc_datapath_ctrl.sv
// Directed bench for mc_datapath_ctrl: the driver applies one input vector
// per cycle and queues the hand-computed output bundle for that cycle; the
// monitor pops and compares on the falling edge.
module tb_mc_datapath_ctrl;

  typedef struct packed {
    logic       mem_rd;
    logic       ir_load;
    logic       op_load;
    logic [3:0] opcode;
    logic       a_load;
    logic       b_load;
    logic [1:0] raddr_a;
    logic [1:0] raddr_b;
    logic [1:0] waddr;
    logic       alu_go;
    logic       rf_we;
    logic       pc_inc;
    logic       busy;
    logic       halted;
    logic       err;
    logic [2:0] state_dbg;
  } outv_t;

  typedef struct {
    string name;
    outv_t exp;
  } item_t;

  // Strobe mask bits used in the vector table.
  localparam logic [8:0] N   = 9'h000;
  localparam logic [8:0] MRD = 9'h100;
  localparam logic [8:0] IRL = 9'h080;
  localparam logic [8:0] OPL = 9'h040;
  localparam logic [8:0] AL  = 9'h020;
  localparam logic [8:0] BL  = 9'h010;
  localparam logic [8:0] GO  = 9'h008;
  localparam logic [8:0] WE  = 9'h004;
  localparam logic [8:0] PC  = 9'h002;
  localparam logic [8:0] ER  = 9'h001;
  localparam logic [8:0] LD3 = OPL | AL | BL;

  logic       clock = 1'b0;
  logic       reset, start, mem_ack;
  logic [7:0] instr;
  logic       mem_rd, ir_load, op_load, a_load, b_load;
  logic [3:0] opcode;
  logic [1:0] raddr_a, raddr_b, waddr;
  logic       alu_go, rf_we, pc_inc, busy, halted, err;
  logic [2:0] state_dbg;
  outv_t      act;

  item_t sb[$];
  int    n_vec = 0;
  int    n_err = 0;

  always #5 clock = ~clock;

  mc_datapath_ctrl #(.MUL_CYCLES(4), .OPW(4)) dut (
    .clock(clock), .reset(reset), .start(start), .mem_ack(mem_ack),
    .instr(instr), .mem_rd(mem_rd), .ir_load(ir_load), .op_load(op_load),
    .opcode(opcode), .a_load(a_load), .b_load(b_load), .raddr_a(raddr_a),
    .raddr_b(raddr_b), .waddr(waddr), .alu_go(alu_go), .rf_we(rf_we),
    .pc_inc(pc_inc), .busy(busy), .halted(halted), .err(err),
    .state_dbg(state_dbg)
  );

  assign act = {mem_rd, ir_load, op_load, opcode, a_load, b_load, raddr_a,
                raddr_b, waddr, alu_go, rf_we, pc_inc, busy, halted, err,
                state_dbg};

  // Build the expected bundle from state, IR contents and the strobe mask.
  function automatic outv_t mk(input logic [2:0] st, input logic [7:0] ir,
                               input logic [8:0] s);
    outv_t o;
    o.mem_rd    = s[8];
    o.ir_load   = s[7];
    o.op_load   = s[6];
    o.a_load    = s[5];
    o.b_load    = s[4];
    o.alu_go    = s[3];
    o.rf_we     = s[2];
    o.pc_inc    = s[1];
    o.err       = s[0];
    o.opcode    = ir[7:4];
    o.raddr_a   = ir[3:2];
    o.raddr_b   = ir[1:0];
    o.waddr     = ir[3:2];
    o.busy      = (st >= 3'd1) && (st <= 3'd4);
    o.halted    = (st == 3'd5);
    o.state_dbg = st;
    return o;
  endfunction

  // One cycle of stimulus plus the outputs expected during that cycle.
  task automatic cyc(input logic st_i, input logic ack_i, input logic rst_i,
                     input logic [7:0] ins_i, input string nm,
                     input logic [2:0] est, input logic [7:0] eir,
                     input logic [8:0] estr);
    item_t it;
    @(posedge clock);
    #1;
    start   = st_i;
    mem_ack = ack_i;
    reset   = rst_i;
    instr   = ins_i;
    it.name = nm;
    it.exp  = mk(est, eir, estr);
    sb.push_back(it);
  endtask

  // Monitor: compare the DUT outputs against the queued expectation.
  initial begin
    item_t it;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        it = sb.pop_front();
        n_vec++;
        if (act !== it.exp) begin
          n_err++;
          $display("FAIL %s: got %h expected %h (state_dbg got %0d exp %0d)",
                   it.name, act, it.exp, act.state_dbg, it.exp.state_dbg);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    reset = 1'b1; start = 1'b0; mem_ack = 1'b0; instr = 8'h00;
    repeat (2) @(posedge clock);
    //   start ack rst instr  name            state IR     strobes
    cyc(1'b0, 1'b0, 1'b1, 8'h00, "reset_idle",  3'd0, 8'h00, N);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, "idle_start",  3'd0, 8'h00, N);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, "fetch_wait",  3'd1, 8'h00, MRD);
    cyc(1'b0, 1'b1, 1'b0, 8'h26, "fetch_add",   3'd1, 8'h00, MRD | IRL);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "dec_add",     3'd2, 8'h26, LD3);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "exec_add",    3'd3, 8'h26, GO);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "wb_add",      3'd4, 8'h26, WE | PC);
    cyc(1'b0, 1'b1, 1'b0, 8'h8D, "fetch_mul",   3'd1, 8'h26, MRD | IRL);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "dec_mul",     3'd2, 8'h8D, LD3);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "exec_mul0",   3'd3, 8'h8D, GO);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "exec_mul1",   3'd3, 8'h8D, GO);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "exec_mul2",   3'd3, 8'h8D, GO);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "exec_mul3",   3'd3, 8'h8D, GO);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "wb_mul",      3'd4, 8'h8D, WE | PC);
    cyc(1'b0, 1'b1, 1'b0, 8'h05, "fetch_nop",   3'd1, 8'h8D, MRD | IRL);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "dec_nop",     3'd2, 8'h05, PC);
    cyc(1'b0, 1'b1, 1'b0, 8'hF0, "fetch_halt",  3'd1, 8'h05, MRD | IRL);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "dec_halt",    3'd2, 8'hF0, PC);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "halted_hold", 3'd5, 8'hF0, N);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, "halted_start",3'd5, 8'hF0, N);
    cyc(1'b0, 1'b1, 1'b0, 8'hA3, "fetch_ill",   3'd1, 8'hF0, MRD | IRL);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "dec_ill",     3'd2, 8'hA3, ER);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, "idle_after_err", 3'd0, 8'hA3, N);
    cyc(1'b0, 1'b1, 1'b0, 8'h8D, "fetch_mul_b", 3'd1, 8'hA3, MRD | IRL);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "dec_mul_b",   3'd2, 8'h8D, LD3);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "exec_mul_b0", 3'd3, 8'h8D, GO);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, "exec_mul_rst",3'd3, 8'h8D, GO);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "post_reset",  3'd0, 8'h00, N);
    cyc(1'b1, 1'b0, 1'b1, 8'h00, "idle_rst_start", 3'd0, 8'h00, N);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "rst_wins",    3'd0, 8'h00, N);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "idle_hold",   3'd0, 8'h00, N);

    // Let the monitor drain the queue, within a bounded number of cycles.
    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clock);
      waited++;
    end
    @(negedge clock);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0",
               sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
